// File: rtl/timing_seq_pkg.sv
// Shared defaults and control-priority encoding for the timing sequence decoder.
package timing_seq_pkg;

  localparam int W_DEF    = 4;
  localparam int LAST_DEF = (1 << W_DEF) - 1;

  typedef enum logic [1:0] {
    CTL_HOLD = 2'd0,
    CTL_INC  = 2'd1,
    CTL_LD   = 2'd2,
    CTL_CLR  = 2'd3
  } ctl_e;

  // Resolve simultaneous strobes: clr beats ld beats inc.
  function automatic ctl_e ctl_decode(input logic clr, input logic ld, input logic inc);
    ctl_e r;
    if (clr) begin
      r = CTL_CLR;
    end else if (ld) begin
      r = CTL_LD;
    end else if (inc) begin
      r = CTL_INC;
    end else begin
      r = CTL_HOLD;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_n_2n.sv
// N-to-2**N one-hot decoder with active-high enable; all outputs low when disabled.
module dec_n_2n #(
  parameter int N = 4
) (
  input  logic [N-1:0]        a,
  input  logic                en,
  output logic [(1<<N)-1:0]   y
);

  // One-hot decode of a, gated by en.
  always_comb begin
    y = '0;
    if (en) begin
      y[a] = 1'b1;
    end else begin
      y = '0;
    end
  end

endmodule

// File: rtl/timing_seq_dec.sv
// Sequence counter with clear/load/increment and one-hot timing decode.
// Optional wrap pulse output is built when TIMING_SEQ_WRAP_PULSE_EN is defined.
module timing_seq_dec
  import timing_seq_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int LAST = (1 << W) - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                ld,
  input  logic [W-1:0]        ld_val,
  input  logic                inc,
  input  logic                en,
  output logic [W-1:0]        sc,
`ifdef TIMING_SEQ_WRAP_PULSE_EN
  output logic                wrap,
`endif
  output logic [(1<<W)-1:0]   t
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  ctl_e         ctl_s;
  logic [W-1:0] ld_clamp_s;
  logic [W-1:0] sc_nxt_s;
  logic [W-1:0] sc_r;

  // Prioritised control action for this edge.
  always_comb begin
    ctl_s = ctl_decode(clr, ld, inc);
  end

  // Loads beyond the terminal count saturate so sc can never exceed LAST.
  always_comb begin
    if (ld_val > LAST_V) begin
      ld_clamp_s = LAST_V;
    end else begin
      ld_clamp_s = ld_val;
    end
  end

  // Next-count selection.
  always_comb begin
    case (ctl_s)
      CTL_CLR:  sc_nxt_s = '0;
      CTL_LD:   sc_nxt_s = ld_clamp_s;
      CTL_INC:  sc_nxt_s = (sc_r == LAST_V) ? '0 : sc_r + W'(1'b1);
      CTL_HOLD: sc_nxt_s = sc_r;
      default:  sc_nxt_s = sc_r;
    endcase
  end

  // Sequence counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_r <= '0;
    end else begin
      sc_r <= sc_nxt_s;
    end
  end

  assign sc = sc_r;

`ifdef TIMING_SEQ_WRAP_PULSE_EN
  logic wrap_r;

  // Only a genuine increment past LAST pulses wrap; clr/ld to zero do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= (ctl_s == CTL_INC) && (sc_r == LAST_V);
    end
  end

  assign wrap = wrap_r;
`endif

  // Decode straight from the register so t follows sc with no extra latency.
  dec_n_2n #(.N(W)) u_dec (
    .a  (sc_r),
    .en (en),
    .y  (t)
  );

endmodule

// File: tb/tb_timing_seq_dec.sv
// Randomised self-checking bench: full-range (LAST=15) and short (LAST=4) instances.
module tb_timing_seq_dec;

  logic        clk = 1'b0;
  logic        rst_n, clr, ld, inc, en;
  logic [3:0]  ld_val;
  logic [3:0]  sc_a, sc_b;
  logic [15:0] t_a, t_b;
`ifdef TIMING_SEQ_WRAP_PULSE_EN
  logic        wrap_a, wrap_b;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int m_a, m_b;
  bit mw_a, mw_b;

  always #5 clk = ~clk;

  timing_seq_dec #(.W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .ld_val(ld_val),
    .inc(inc), .en(en), .sc(sc_a),
`ifdef TIMING_SEQ_WRAP_PULSE_EN
    .wrap(wrap_a),
`endif
    .t(t_a)
  );

  timing_seq_dec #(.W(4), .LAST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .ld_val(ld_val),
    .inc(inc), .en(en), .sc(sc_b),
`ifdef TIMING_SEQ_WRAP_PULSE_EN
    .wrap(wrap_b),
`endif
    .t(t_b)
  );

  // Reference: next count from the priority rules, as plain arithmetic.
  function automatic int next_sc(int cur, int last);
    if (clr) return 0;
    if (ld) return (int'(ld_val) > last) ? last : int'(ld_val);
    if (inc) return (cur + 1) % (last + 1);
    return cur;
  endfunction

  function automatic logic [15:0] onehot(int s);
    return en ? (16'd1 << s) : 16'd0;
  endfunction

  // Advance one clock and update the reference model; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_a = 0; m_b = 0; mw_a = 1'b0; mw_b = 1'b0;
    end else begin
      mw_a = !clr && !ld && inc && (m_a == 15);
      mw_b = !clr && !ld && inc && (m_b == 4);
      m_a = next_sc(m_a, 15);
      m_b = next_sc(m_b, 4);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; ld = 1'b0; inc = 1'b0; ld_val = 4'd0;
    m_a = 0; m_b = 0; mw_a = 1'b0; mw_b = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      clr = 1'($urandom); ld = 1'($urandom); inc = 1'($urandom); ld_val = 4'($urandom);
      if (i > 0) step();
      vec_cnt++;
      if (sc_a !== 4'd0 || t_a !== 16'h0001 || sc_b !== 4'd0 || t_b !== 16'h0001) begin
        err_cnt++;
        $display("FAIL reset[%0d]: sc_a=%0d t_a=%h sc_b=%0d t_b=%h, required sc=0 t=0001", i, sc_a, t_a, sc_b, t_b);
      end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
      vec_cnt++;
      if (wrap_a !== 1'b0 || wrap_b !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_wrap[%0d]: wrap_a=%b wrap_b=%b, required 0", i, wrap_a, wrap_b);
      end
`endif
    end
  endtask

  task automatic test_count_wrap();
    clr = 1'b0; ld = 1'b0; inc = 1'b0; en = 1'b1;
    rst_n = 1'b1;
    inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      vec_cnt++;
      if (sc_a !== 4'(m_a) || t_a !== onehot(m_a) || m_a != (i + 1) % 16) begin
        err_cnt++;
        $display("FAIL count[%0d]: sc=%0d t=%h, required sc=%0d t=%h", i, sc_a, t_a, (i + 1) % 16, onehot((i + 1) % 16));
      end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
      vec_cnt++;
      if (wrap_a !== mw_a) begin
        err_cnt++;
        $display("FAIL count_wrap[%0d]: wrap=%b, required %b", i, wrap_a, mw_a);
      end
`endif
    end
    inc = 1'b0;
    step();
`ifdef TIMING_SEQ_WRAP_PULSE_EN
    vec_cnt++;
    if (wrap_a !== 1'b0) begin
      err_cnt++;
      $display("FAIL wrap_one_cycle: wrap=%b, required 0", wrap_a);
    end
`endif
    vec_cnt++;
    if (sc_a !== 4'(m_a)) begin
      err_cnt++;
      $display("FAIL count_hold: sc=%0d, required %0d", sc_a, m_a);
    end
  endtask

  task automatic test_short_seq();
    clr = 1'b1; step(); clr = 1'b0;
    inc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vec_cnt++;
      if (sc_b !== 4'(m_b) || t_b !== onehot(m_b) || t_b[15:5] !== 11'd0) begin
        err_cnt++;
        $display("FAIL short[%0d]: sc=%0d t=%h, required sc=%0d t=%h", i, sc_b, t_b, m_b, onehot(m_b));
      end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
      vec_cnt++;
      if (wrap_b !== mw_b) begin
        err_cnt++;
        $display("FAIL short_wrap[%0d]: wrap=%b, required %b", i, wrap_b, mw_b);
      end
`endif
    end
    inc = 1'b0; ld = 1'b1; ld_val = 4'd9;
    step();
    ld = 1'b0;
    vec_cnt++;
    if (sc_b !== 4'd4 || sc_a !== 4'd9 || m_b != 4) begin
      err_cnt++;
      $display("FAIL short_clamp: sc_b=%0d sc_a=%0d, required sc_b=4 sc_a=9", sc_b, sc_a);
    end
  endtask

  task automatic test_priority();
    ld = 1'b1; ld_val = 4'd15; step();
    clr = 1'b1; ld = 1'b1; ld_val = 4'd7; inc = 1'b1;
    step();
    vec_cnt++;
    if (sc_a !== 4'd0 || sc_b !== 4'd0) begin
      err_cnt++;
      $display("FAIL prio_clr: sc_a=%0d sc_b=%0d, required 0", sc_a, sc_b);
    end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
    vec_cnt++;
    if (wrap_a !== 1'b0 || wrap_b !== 1'b0) begin
      err_cnt++;
      $display("FAIL prio_clr_wrap: wrap_a=%b wrap_b=%b, required 0", wrap_a, wrap_b);
    end
`endif
    clr = 1'b0; ld = 1'b1; ld_val = 4'd15; inc = 1'b0; step();
    ld_val = 4'd0; inc = 1'b1; step();
    vec_cnt++;
    if (sc_a !== 4'd0) begin
      err_cnt++;
      $display("FAIL prio_ld0: sc=%0d, required 0", sc_a);
    end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
    vec_cnt++;
    if (wrap_a !== 1'b0 || wrap_b !== 1'b0) begin
      err_cnt++;
      $display("FAIL prio_ld0_wrap: wrap_a=%b wrap_b=%b, required 0", wrap_a, wrap_b);
    end
`endif
    ld_val = 4'd7; step();
    ld = 1'b0; inc = 1'b0;
    vec_cnt++;
    if (sc_a !== 4'd7 || sc_b !== 4'd4 || t_a !== onehot(m_a)) begin
      err_cnt++;
      $display("FAIL prio_ld: sc_a=%0d sc_b=%0d t_a=%h, required 7 4 %h", sc_a, sc_b, t_a, onehot(m_a));
    end
  endtask

  task automatic test_enable_reset();
    ld = 1'b1; ld_val = 4'd5; step();
    ld = 1'b0; en = 1'b0;
    #1;
    vec_cnt++;
    if (t_a !== 16'd0 || sc_a !== 4'd5) begin
      err_cnt++;
      $display("FAIL en_off: t=%h sc=%0d, required t=0000 sc=5", t_a, sc_a);
    end
    step();
    vec_cnt++;
    if (t_a !== 16'd0 || sc_a !== 4'd5 || t_b !== 16'd0 || sc_b !== 4'd4) begin
      err_cnt++;
      $display("FAIL en_hold: t_a=%h sc_a=%0d t_b=%h sc_b=%0d, required 0 5 0 4", t_a, sc_a, t_b, sc_b);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (sc_a !== 4'd0 || sc_b !== 4'd0 || t_a !== 16'd0) begin
      err_cnt++;
      $display("FAIL async_rst: sc_a=%0d sc_b=%0d t=%h, required 0 0 0000", sc_a, sc_b, t_a);
    end
    en = 1'b1;
    #1;
    vec_cnt++;
    if (t_a !== 16'h0001) begin
      err_cnt++;
      $display("FAIL rst_t0: t=%h, required 0001", t_a);
    end
    rst_n = 1'b1;
    m_a = 0; m_b = 0; mw_a = 1'b0; mw_b = 1'b0;
    inc = 1'b1; step(); inc = 1'b0;
    vec_cnt++;
    if (sc_a !== 4'd1 || sc_b !== 4'd1) begin
      err_cnt++;
      $display("FAIL rst_release: sc_a=%0d sc_b=%0d, required 1", sc_a, sc_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr    = ($urandom_range(7) == 0);
      ld     = ($urandom_range(3) == 0);
      inc    = ($urandom_range(1) == 0);
      en     = ($urandom_range(3) != 0);
      rst_n  = ($urandom_range(31) != 0);
      ld_val = 4'($urandom);
      step();
      vec_cnt++;
      if (sc_a !== 4'(m_a) || t_a !== onehot(m_a) || sc_b !== 4'(m_b) || t_b !== onehot(m_b)) begin
        err_cnt++;
        $display("FAIL random[%0d]: sc_a=%0d t_a=%h sc_b=%0d t_b=%h, required %0d %h %0d %h",
                 i, sc_a, t_a, sc_b, t_b, m_a, onehot(m_a), m_b, onehot(m_b));
      end
`ifdef TIMING_SEQ_WRAP_PULSE_EN
      vec_cnt++;
      if (wrap_a !== mw_a || wrap_b !== mw_b) begin
        err_cnt++;
        $display("FAIL random_wrap[%0d]: wrap_a=%b wrap_b=%b, required %b %b", i, wrap_a, wrap_b, mw_a, mw_b);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_short_seq();
    test_priority();
    test_enable_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/timing_seq_dec.md
TIMING_SEQ_DEC -- requirements
Module: timing_seq_dec

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the sequence counter width in bits, legal range 1..6.
REQ-002 The block SHALL have parameter LAST, default 2**W-1, giving the terminal count after which the counter wraps; LAST SHALL be < 2**W.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit, the synchronous clear of the sequence counter.
REQ-006 The block SHALL have port ld, input, 1 bit, the synchronous load strobe.
REQ-007 The block SHALL have port ld_val, input, W bits, the value loaded when ld is high.
REQ-008 The block SHALL have port inc, input, 1 bit, the synchronous increment strobe.
REQ-009 The block SHALL have port en, input, 1 bit, the enable for the decoded outputs.
REQ-010 The block SHALL have port sc, output, W bits, the current sequence count.
REQ-011 The block SHALL have port t, output, 2**W bits, the one-hot decoded timing signals T0..T(2**W-1).
REQ-012 The block SHALL have port wrap, output, 1 bit, the wrap pulse; this port exists only when the configuration macro is defined.

Function
REQ-013 The block SHALL sample control inputs on the rising edge of clk with priority clr > ld > inc > hold.
REQ-014 With clr high, sc SHALL become 0 on the next edge, regardless of ld and inc.
REQ-015 With ld high and clr low, sc SHALL become ld_val; an ld_val greater than LAST SHALL be clamped to LAST.
REQ-016 With inc high, clr low and ld low, sc SHALL become sc+1, or 0 when sc==LAST (wrap-around).
REQ-017 With no control input high, sc SHALL hold its value.
REQ-018 t SHALL be combinational from sc and en: t[sc]=1 and all other bits 0 when en=1; t SHALL be all 0 when en=0.
REQ-019 t SHALL reflect a control action in the same cycle that sc changes, with zero added latency after the capturing edge.
REQ-020 t bits with index > LAST SHALL never assert.
REQ-021 sc SHALL never exceed LAST under any input sequence.

Reset
REQ-022 Assertion of rst_n low SHALL immediately force sc=0 and wrap=0, independent of clk.
REQ-023 During reset, t SHALL equal {0..0, en}, so that only t[0] may be high.
REQ-024 Reset SHALL override any in-progress clr, ld or inc; the first action after deassertion is taken on the first rising edge with rst_n high.

Configuration
REQ-025 When macro TIMING_SEQ_WRAP_PULSE_EN is defined, the wrap port and its register SHALL be present.
REQ-026 With TIMING_SEQ_WRAP_PULSE_EN defined, wrap SHALL be high for exactly one cycle following an edge on which an inc action moved sc from LAST to 0.
REQ-027 With TIMING_SEQ_WRAP_PULSE_EN defined, wrap SHALL stay low when clr or ld forces sc to 0.
REQ-028 When TIMING_SEQ_WRAP_PULSE_EN is not defined, the wrap port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Package timing_seq_pkg SHALL hold the default W, the default LAST, and the control-priority encoding constants.
REQ-030 The N-to-2**N decoder with enable SHALL be a separate parametrised sub-module, dec_n_2n, instantiated once with N=W.

Verification
REQ-031 Reset test: hold rst_n=0 with en=1, apply clk edges -> sc=0, t=0x0001 and wrap=0 throughout.
REQ-032 Count and wrap test (W=4, LAST=15): apply inc for 16 cycles from 0 -> sc steps 1..15 then 0, and t walks one-hot 0x0002..0x8000 then 0x0001; with the macro defined, wrap=1 in exactly the cycle after the 15->0 edge.
REQ-033 Short sequence test (LAST=4): hold inc=1 -> sc cycles 0,1,2,3,4,0; t[15:5] stays 0; ld_val=9 loads sc=4.
REQ-034 Priority test: apply clr=1, ld=1, ld_val=7, inc=1 on one edge -> sc=0 and wrap=0; then apply ld=1, inc=1, ld_val=7 -> sc=7.
REQ-035 Enable and mid-operation reset test: with sc=5, set en=0 -> t=0 while sc holds 5; then pulse rst_n low between edges -> sc=0 immediately, with no clk edge needed.
